// File: rtl/frame_store_ctrl.sv
// Frame store for the camera capture path.
// The write side is addressed by an internal pixel counter.
// The read side is random-access with a registered output.
// Optional ping-pong double buffering and continuous re-arm are supported.
module frame_store_ctrl #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = 19,
  parameter int unsigned DOUBLE_BUF = 1
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          arm_i,
  input  logic          cont_i,
  input  logic          sof_i,
  input  logic          we_i,
  input  logic [DW-1:0] dat_i,
  input  logic          re_i,
  input  logic [AW-1:0] adr_i,
  output logic [DW-1:0] dat_o,
  output logic          valid_o,
  output logic          fin_o,
  output logic          frame_done_o,
  output logic          err_o,
  output logic          wr_bank_o,
  output logic          rd_bank_o
);

  localparam int unsigned N    = H_ACT * V_ACT;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NB   = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int unsigned MA   = (NB * N > 1) ? $clog2(NB * N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [AW:0]   N_AW = (AW + 1)'(N);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] wr_px;
  logic          bank_q;
  logic          mem_we, last_px, short_sof, start_frm, arm_clr;
  logic [MA-1:0] wr_addr, rd_addr;
  logic          rd_in_range;

  logic [DW-1:0] mem [NB*N];

  // Bank indices: read bank is always the complement of the write bank when double-buffered.
  assign wr_bank_o = (DOUBLE_BUF != 0) ? bank_q  : 1'b0;
  assign rd_bank_o = (DOUBLE_BUF != 0) ? ~bank_q : 1'b0;

  // Both banks live in one flat array; bank 1 occupies the upper N words.
  assign wr_addr     = ((wr_bank_o) ? MA'(N) : '0) + MA'(wr_px);
  assign rd_addr     = ((rd_bank_o) ? MA'(N) : '0) + MA'(adr_i);
  assign rd_in_range = ({1'b0, adr_i} < N_AW);

  // Capture FSM next-state and write decode.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_px     = '0;
    mem_we    = 1'b0;
    last_px   = 1'b0;
    short_sof = 1'b0;
    start_frm = 1'b0;
    arm_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = WAIT_SOF;
          arm_clr = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (we_i && sof_i) begin
          mem_we    = 1'b1;
          wr_cnt_d  = CW'(1);
          state_d   = CAPTURE;
          start_frm = 1'b1;
        end
      end
      CAPTURE: begin
        if (we_i) begin
          mem_we = 1'b1;
          // The last pixel takes priority over a coincident sof_i.
          if (wr_cnt_q == LAST) begin
            wr_px    = wr_cnt_q;
            last_px  = 1'b1;
            wr_cnt_d = '0;
            state_d  = cont_i ? WAIT_SOF : IDLE;
          end else if (sof_i) begin
            short_sof = 1'b1;
            wr_cnt_d  = CW'(1);
          end else begin
            wr_px    = wr_cnt_q;
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, bank swap and status flags.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      bank_q       <= 1'b0;
      fin_o        <= 1'b0;
      err_o        <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      frame_done_o <= last_px;
      if (last_px && (DOUBLE_BUF != 0))
        bank_q <= ~bank_q;
      // A single bank stops holding a whole frame once the next one starts.
      if (last_px)
        fin_o <= 1'b1;
      else if (start_frm && (DOUBLE_BUF == 0))
        fin_o <= 1'b0;
      if (arm_clr)
        err_o <= 1'b0;
      else if (short_sof)
        err_o <= 1'b1;
    end
  end

  // Pixel storage; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (mem_we)
      mem[wr_addr] <= dat_i;
  end

  // Registered read port; out-of-range addresses return zero.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      dat_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= re_i;
      if (re_i)
        dat_o <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: doc/frame_store_ctrl.md
# frame_store_ctrl

Parametrised frame store for the camera capture path: a counter-addressed write side driven by the pixel stream, plus a random-access registered read side for the display/readout logic. Supports optional ping-pong double buffering and single-shot or continuous capture. Frame completion is reported by a level flag and a one-cycle pulse. Sits between the camera pixel formatter and the video readout, replacing the fixed 640x480x8 frame RAM.

## Interface
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- DW, 8, pixel width in bits
- AW, 19, read address width; must satisfy 2^AW >= H_ACT*V_ACT
- DOUBLE_BUF, 1, 1 = two banks with ping-pong swap; 0 = single bank

- clk_i  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- arm_i  in  1  start capture from IDLE; clears err_o
- cont_i  in  1  1 = re-arm automatically after each frame
- sof_i  in  1  marks the first pixel of a frame; qualified by we_i
- we_i  in  1  pixel valid
- dat_i  in  DW  pixel data
- re_i  in  1  read request
- adr_i  in  AW  read address = line*H_ACT + column
- dat_o  out  DW  read data, registered
- valid_o  out  1  dat_o valid, one-cycle pulse
- fin_o  out  1  a complete frame is readable
- frame_done_o  out  1  one-cycle pulse per completed frame
- err_o  out  1  sticky short-frame error
- wr_bank_o, rd_bank_o  out  1  current bank indices (tied 0 when DOUBLE_BUF=0)

## Operation
- N = H_ACT*V_ACT. Internal write counter wr_cnt is clog2(N) bits wide.
- States: IDLE, WAIT_SOF, CAPTURE.
  - IDLE: we_i is ignored. arm_i=1 -> WAIT_SOF.
  - WAIT_SOF: we_i without sof_i is ignored. we_i&sof_i writes dat_i at address 0, sets wr_cnt=1, and moves to CAPTURE.
  - CAPTURE: each we_i writes bank[wr_bank][wr_cnt] and increments wr_cnt. arm_i is ignored.
- Last pixel: we_i while wr_cnt==N-1.
  - Write the pixel, pulse frame_done_o, set fin_o=1.
  - If DOUBLE_BUF: swap wr_bank and rd_bank.
  - Next state is WAIT_SOF if cont_i=1, else IDLE.
- Short frame: we_i&sof_i in CAPTURE before the last pixel.
  - Set err_o.
  - Write the pixel at address 0, set wr_cnt=1, stay in CAPTURE.
  - No swap, no frame_done_o.
- sof_i without we_i has no effect.
- fin_o:
  - DOUBLE_BUF=1: once set, held until reset.
  - DOUBLE_BUF=0: cleared on WAIT_SOF -> CAPTURE, because the single bank is being overwritten.
- Read port:
  - re_i samples adr_i and rd_bank (the bank index before any swap on that edge).
  - adr_i >= N returns dat_o=0, still with valid_o.
  - DOUBLE_BUF=0, read and write to the same address on the same edge: dat_o returns the old data.
- Memory contents are not reset.

## Timing
- Reset values:
  - State IDLE, wr_cnt=0.
  - dat_o=0, valid_o=0, fin_o=0, frame_done_o=0, err_o=0.
  - wr_bank_o=0; rd_bank_o=1 (DOUBLE_BUF=1) or 0 (DOUBLE_BUF=0).
- Reset asserted mid-capture: aborts the frame, no frame_done_o, no swap.
- Write latency: a pixel accepted at edge k is readable by a re_i sampled at edge k+1 or later.
- Read latency: re_i at edge k -> dat_o and valid_o=1 after edge k+1. Back-to-back reads give one result per cycle.
- Last pixel at edge k: frame_done_o=1, fin_o=1 and new bank indices all visible after edge k, for exactly one cycle (frame_done_o).
- arm_i at edge k: state WAIT_SOF after edge k, err_o=0 after edge k.
- Simultaneous events:
  - Read sampled on the same edge as a swap uses the old rd_bank.
  - Last pixel together with cont_i=1 and the next sof_i: the next frame's sof is accepted at the earliest one cycle after the last pixel (WAIT_SOF must be entered first).

## Test plan
- H_ACT=4, V_ACT=2, DOUBLE_BUF=1, cont_i=0; arm, then 8 pixels 0x10..0x17 with sof on the first -> frame_done_o pulses once, fin_o=1, rd_bank_o=0; reads at 0..7 return 0x10..0x17 with one-cycle latency; state returns to IDLE.
- Continuous mode, two frames (0x20.., then 0x30..) -> banks alternate; after frame 2, reads return 0x30..; a read issued during frame 2 returns frame-1 data.
- sof after 3 pixels -> err_o=1, no frame_done_o; the frame restarts at address 0 and completes normally; a subsequent arm_i clears err_o.
- DOUBLE_BUF=0: fin_o=1 after frame 1 and drops when frame 2's sof is accepted; a same-edge read and write at address 2 returns the old value.
- Assert rst after 5 pixels -> all outputs at their reset values immediately; pixels while in IDLE are ignored; no frame_done_o.
- Read at adr_i=N (8) -> dat_o=0, valid_o=1; re_i held high for 4 cycles -> 4 consecutive valid results.
